dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the core's load/store port, serving word requests over a valid/ready request channel and a valid/ready response channel.
- Sits between the memory stage and a word-organised RAM array, replacing the zero-latency data memory.
- Programmable wait states let the pipeline's stall path be exercised.
- Reports misaligned and out-of-range accesses via an error flag.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, extra cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for store; bit i enables byte i (wdata[8i+7:8i]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  access was misaligned or out of range.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on rising clk.
- Reset values:
  - state = IDLE, wait counter = 0.
  - req_ready = 1 (combinational from IDLE); rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Memory array contents are NOT cleared by rst.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid, capture write, addr, wdata, be; load counter = WAIT_CYCLES.
    - Go to WAIT if WAIT_CYCLES > 0, else RESP.
  - WAIT: req_ready = 0. Decrement counter each cycle; go to RESP when counter reaches 1.
  - RESP: req_ready = 0; rsp_valid = 1. rsp_rdata and rsp_err stay stable until rsp_ready = 1 is sampled, then go to IDLE.
    - rsp_valid drops the next cycle.
    - No new request is accepted in the same cycle the response handshakes.
- Latency: request accepted at edge T gives rsp_valid = 1 from T+1+WAIT_CYCLES, when rsp_ready is held high.
- Commit point: array read and write occur on the edge that enters RESP; rsp_rdata is registered at that edge.
- Error check (on captured address):
  - err = (addr[1:0] != 0) OR (addr[31:ADDR_WIDTH+2] != 0).
  - On err: no array write; rsp_rdata = 0; rsp_err = 1.
- Store with no error:
  - For each i with be[i] = 1, mem[addr[ADDR_WIDTH+1:2]] byte i <= wdata byte i.
  - Other bytes are unchanged; rsp_rdata = 0, rsp_err = 0.
  - be = 4'b0000 leaves the word unchanged and still gives a normal response.
- Load with no error: rsp_rdata = full word at mem[addr[ADDR_WIDTH+1:2]]; req_be is ignored.
- Request fields change while req_ready = 0: ignored; only captured values are used.
- rst mid-operation:
  - Asserted in WAIT: the pending store is dropped (not yet committed).
  - Asserted in RESP: the response is discarded; an already-committed store remains.
  - Either case returns to IDLE with the reset output values.
- Back-to-back: at most one outstanding request. Throughput is one request per 2+WAIT_CYCLES cycles with rsp_ready held high.

Test Plan:
- Reset then idle: rst 1 for 2 cycles -> req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Store/load round trip (WAIT_CYCLES = 2):
  - Store addr 0x10, wdata 0xDEADBEEF, be 4'hF accepted at cycle 0 -> rsp_valid at cycle 3, err 0, rdata 0.
  - Load 0x10 -> rdata 0xDEADBEEF.
- Byte enables: word 0x10 = 0xDEADBEEF; store wdata 0x11223344, be 4'b0101 -> load 0x10 returns 0xDE22BE44.
- Errors:
  - Load at 0x13 -> rsp_err = 1, rdata 0.
  - Store at 0x00001000 with ADDR_WIDTH = 10 -> rsp_err = 1, and a load of 0x0 shows it unchanged.
- Response backpressure: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rdata, err stable and req_ready = 0 throughout; accept on rsp_ready = 1, then req_ready = 1 the next cycle.
- Reset mid-WAIT: store 0x20 = 0xCAFEF00D; assert rst in WAIT -> after reset, load 0x20 returns the prior value. Repeat with WAIT_CYCLES = 0 -> rsp_valid at cycle 1.

Source files
------------

// File: rtl/dmem_if.sv
// Load/store port between the core's memory stage and the data-memory responder.
// The master drives requests and accepts responses; the slave is the memory end.
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory behind a valid/ready load/store port, with a fixed
// number of wait states between request acceptance and response.
module dmem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic  clk,
   input  logic  rst,
   dmem_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam int         DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic [31:0] mem [0:DEPTH-1];

   logic                  commit;
   logic                  mem_we;
   logic                  cur_wr;
   logic [31:0]           cur_addr;
   logic [31:0]           cur_wdata;
   logic [3:0]            cur_be;
   logic                  cur_err;
   logic [ADDR_WIDTH-1:0] cur_idx;

   // With zero wait states the commit happens on the accepting edge, so the
   // access must use the live request rather than the not-yet-captured copy.
   always_comb begin
      if (state_q == S_IDLE) begin
         cur_wr    = bus.req_write;
         cur_addr  = bus.req_addr;
         cur_wdata = bus.req_wdata;
         cur_be    = bus.req_be;
      end else begin
         cur_wr    = wr_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
         cur_be    = be_q;
      end
   end

   assign cur_idx = cur_addr[ADDR_WIDTH+1:2];
   assign cur_err = (cur_addr[1:0] != 2'b00) ||
                    ((cur_addr >> (ADDR_WIDTH + 2)) != 32'd0);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      commit      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               wr_d    = bus.req_write;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               be_d    = bus.req_be;
               cnt_d   = WAIT_INIT;
               if (WAIT_CYCLES == 0) begin
                  commit  = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd1) begin
               commit  = 1'b1;
               state_d = S_RESP;
            end
            cnt_d = cnt_q - 4'd1;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (commit) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = cur_err;
         rsp_rdata_d = (!cur_wr && !cur_err) ? mem[cur_idx] : 32'd0;
      end
   end

   // A reset landing on the commit edge drops the store.
   assign mem_we = commit && cur_wr && !cur_err && !rst;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         wr_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         be_q        <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // NOTE: the array has no reset; its contents survive rst and it can map to RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
         end
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule
